// File: rtl/rtc_read_sequencer.sv
// Read-side RTC bus sequencer: walks 9 time/timer registers over the muxed
// active-low bus, collects them in shadows and commits them as one snapshot.
module rtc_read_sequencer #(
  parameter int unsigned PHASE = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hour,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_REL, S_DATA, S_DATA_REL, S_COMMIT
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(PHASE - 1);
  localparam logic [3:0] IDX_LAST = 4'd8;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic       phase_end;
  logic       capture;

  logic [7:0] shadow_q [9];
  logic [7:0] out_q    [9];

  // Time block 0x21..0x26 first, then timer block 0x41..0x43.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign phase_end = (cnt_q == PH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = idx_q;
    cs_n    = 1'b1;
    ad_sel  = 1'b1;
    wr_n    = 1'b1;
    rd_n    = 1'b1;
    ad_oe   = 1'b0;
    ad_out  = 8'h00;
    busy    = 1'b1;
    done    = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          state_d = S_ADDR;
          idx_d   = '0;
        end
      end
      S_ADDR: begin
        cs_n   = 1'b0;
        ad_sel = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = reg_addr(idx_q);
        if (phase_end) begin
          state_d = S_ADDR_REL;
          cnt_d   = '0;
        end
      end
      S_ADDR_REL: begin
        // Keep driving the address after the strobe rises for hold time.
        ad_oe  = 1'b1;
        ad_out = reg_addr(idx_q);
        if (phase_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        if (phase_end) begin
          capture = 1'b1;
          state_d = S_DATA_REL;
          cnt_d   = '0;
        end
      end
      S_DATA_REL: begin
        if (phase_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_COMMIT: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadows fill one per register; outputs only move together on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      if (capture) shadow_q[idx_q] <= ad_in;
      if (state_q == S_COMMIT) out_q <= shadow_q;
    end
  end

  assign seg    = out_q[0];
  assign min    = out_q[1];
  assign hour   = out_q[2];
  assign day    = out_q[3];
  assign month  = out_q[4];
  assign year   = out_q[5];
  assign t_seg  = out_q[6];
  assign t_min  = out_q[7];
  assign t_hour = out_q[8];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: RTC bus model, frame vector table with a
// snapshot scoreboard, window/address monitor and bus-safety monitors.
module tb_rtc_read_sequencer;

  localparam int P  = 9;
  localparam int P2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, cs_n, ad_sel, wr_n, rd_n, busy, done;
  logic [7:0] seg, min, hour, day, month, year, t_seg, t_min, t_hour;

  logic       reset2, start2;
  logic [7:0] ad_in2, ad_out2;
  logic       ad_oe2, cs_n2, ad_sel2, wr_n2, rd_n2, busy2, done2;
  logic [7:0] seg2, min2, hour2, day2, month2, year2, t_seg2, t_min2, t_hour2;

  rtc_read_sequencer #(.PHASE(P)) dut (
    .clk(clk), .reset(reset), .start(start), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .ad_sel(ad_sel), .wr_n(wr_n), .rd_n(rd_n),
    .seg(seg), .min(min), .hour(hour), .day(day), .month(month), .year(year),
    .t_seg(t_seg), .t_min(t_min), .t_hour(t_hour), .busy(busy), .done(done)
  );

  rtc_read_sequencer #(.PHASE(P2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .ad_in(ad_in2), .ad_out(ad_out2),
    .ad_oe(ad_oe2), .cs_n(cs_n2), .ad_sel(ad_sel2), .wr_n(wr_n2), .rd_n(rd_n2),
    .seg(seg2), .min(min2), .hour(hour2), .day(day2), .month(month2), .year(year2),
    .t_seg(t_seg2), .t_min(t_min2), .t_hour(t_hour2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // RTC model: latches the address strobe, returns base + register index on reads.
  logic [7:0] base = 8'h10;
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk) if (!cs_n && !ad_sel) lat_addr <= ad_out;

  function automatic logic [7:0] addr2idx(input logic [7:0] a);
    case (a)
      8'h21: return 8'd0;
      8'h22: return 8'd1;
      8'h23: return 8'd2;
      8'h24: return 8'd3;
      8'h25: return 8'd4;
      8'h26: return 8'd5;
      8'h41: return 8'd6;
      8'h42: return 8'd7;
      8'h43: return 8'd8;
      default: return 8'hE0;
    endcase
  endfunction

  assign ad_in  = !rd_n  ? base + addr2idx(lat_addr) : 8'hFF;
  assign ad_in2 = !rd_n2 ? 8'h3C : 8'hFF;

  logic [71:0] snap, snap2;
  assign snap  = {seg, min, hour, day, month, year, t_seg, t_min, t_hour};
  assign snap2 = {seg2, min2, hour2, day2, month2, year2, t_seg2, t_min2, t_hour2};

  logic [7:0] addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  // Monitor on the main instance: done count, output stability, windows, safety.
  int          done_cnt = 0;
  logic [71:0] prev_snap = '0;
  logic        prev_done = 1'b0, prev_rst = 1'b1;
  int          win_idx = 0, run_len = 0, prev_kind = 0, kind;
  bit          run_valid = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && !prev_rst && !prev_done && snap !== prev_snap)
      chk("stable_between_commits", snap, prev_snap);
    prev_snap = snap;
    prev_done = done;
    prev_rst  = reset;
    if (!reset) begin
      chk("oe_vs_rd", 72'(ad_oe && !rd_n), 72'(0));
      chk("wr_vs_rd", 72'(!wr_n && !rd_n), 72'(0));
    end
    kind = (!cs_n && !ad_sel && !wr_n) ? 1 : (!cs_n && ad_sel && !rd_n) ? 2 : 0;
    if (reset) begin
      win_idx = 0; run_len = 0; prev_kind = 0; run_valid = 0;
    end else begin
      if (kind != prev_kind) begin
        if (prev_kind != 0 && run_valid) chk("window_len", 72'(run_len), 72'(P));
        if (kind == 1) begin
          chk("addr_seq", 72'(ad_out), 72'(addr_tbl[win_idx]));
          win_idx = (win_idx + 1) % 9;
        end
        run_len = 1;
        run_valid = 1;
      end else begin
        run_len++;
      end
      prev_kind = kind;
    end
  end

  // Back-to-back PHASE=2 instance: bus safety, period and committed data.
  int  cyc2 = 0, last2 = -1;
  bit  commit2_seen = 0;
  always @(negedge clk) begin
    cyc2++;
    if (!reset2) begin
      chk("p2_oe_vs_rd", 72'(ad_oe2 && !rd_n2), 72'(0));
      chk("p2_wr_vs_rd", 72'(!wr_n2 && !rd_n2), 72'(0));
      if (!cs_n2 && !ad_sel2) chk("p2_addr_block", 72'(ad_out2[7:4] == 4'h2 || ad_out2[7:4] == 4'h4), 72'(1));
      if (commit2_seen) chk("p2_snapshot", snap2, {9{8'h3C}});
      commit2_seen = done2;
      if (done2) begin
        chk("p2_busy_in_commit", 72'(busy2), 72'(1));
        if (last2 >= 0) chk("p2_period", 72'(cyc2 - last2), 72'(36 * P2 + 2));
        last2 = cyc2;
      end
    end
  end

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  nbase;
    int          chg_t;
    bit          ign;
    logic [71:0] exp;
  } vec_t;

  vec_t        tbl [5];
  logic [71:0] sb [$];
  logic [71:0] last_exp = '0;

  task automatic run_frame(input vec_t v);
    int t;
    int d0;
    logic [71:0] e;
    d0 = done_cnt;
    base = v.base;
    start = 1'b1;
    sb.push_back(v.exp);
    tick();
    start = 1'b0;
    t = 1;
    chk("busy_first_cycle", 72'(busy), 72'(1));
    while (!done && t < 1000) begin
      if (v.chg_t != 0 && t == v.chg_t) base = v.nbase;
      start = v.ign && (t == 50 || t == 200);
      if (t == 300) chk("hold_midframe", snap, last_exp);
      tick();
      t++;
    end
    start = 1'b0;
    chk("done_cycle", 72'(t), 72'(36 * P + 1));
    chk("busy_in_commit", 72'(busy), 72'(1));
    tick();
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("snapshot", snap, e);
    last_exp = e;
    chk("busy_after_commit", 72'(busy), 72'(0));
    chk("done_once", 72'(done_cnt - d0), 72'(1));
    if (v.ign) begin
      repeat (400) tick();
      chk("no_restart", 72'(done_cnt - d0), 72'(1));
      chk("idle_after_ignored", 72'(busy), 72'(0));
    end
  endtask

  initial begin
    int bad;
    int d0;
    tbl[0] = '{8'h10, 8'h00, 0,   1'b0, 72'h10_11_12_13_14_15_16_17_18};
    tbl[1] = '{8'h50, 8'hA0, 140, 1'b0, 72'h50_51_52_53_A4_A5_A6_A7_A8};
    tbl[2] = '{8'h00, 8'h00, 0,   1'b1, 72'h00_01_02_03_04_05_06_07_08};
    tbl[3] = '{8'h90, 8'h00, 0,   1'b0, 72'h90_91_92_93_94_95_96_97_98};
    tbl[4] = '{8'hF0, 8'h00, 0,   1'b0, 72'hF0_F1_F2_F3_F4_F5_F6_F7_F8};

    reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    repeat (3) tick();
    chk("reset_ctrl", 72'({cs_n, ad_sel, wr_n, rd_n, ad_oe, busy, done}), 72'(7'b1111000));
    chk("reset_ad_out", 72'(ad_out), 72'(0));
    chk("reset_outputs", snap, 72'(0));
    reset = 1'b0; reset2 = 1'b0; start2 = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!(cs_n && ad_sel && wr_n && rd_n && !ad_oe && !busy && !done &&
            ad_out == 8'h00 && snap == 72'(0))) bad++;
    end
    chk("idle_100_cycles", 72'(bad), 72'(0));

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Reset during DATA of register 4 discards the frame and clears outputs.
    d0 = done_cnt;
    base = 8'h70;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 165; t++) tick();
    chk("pre_reset_in_data", 72'({cs_n, ad_sel, rd_n}), 72'(3'b010));
    reset = 1'b1;
    tick();
    chk("midreset_ctrl", 72'({cs_n, ad_sel, wr_n, rd_n, ad_oe, busy, done}), 72'(7'b1111000));
    chk("midreset_outputs", snap, 72'(0));
    reset = 1'b0;
    last_exp = '0;
    tick();
    chk("aborted_no_done", 72'(done_cnt - d0), 72'(0));
    run_frame(tbl[0]);

    chk("scoreboard_empty", 72'(sb.size()), 72'(0));
    chk("p2_commits_seen", 72'(last2 >= 0), 72'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_read_sequencer.md
# rtc_read_sequencer

Reads the RTC time and timer registers over the multiplexed, active-low address/data bus and presents a coherent snapshot to the display and control logic. It is the read-side counterpart of the initialization sequencer, which only writes register 0x02. Each frame reads 9 registers in a fixed order. Values are captured into shadow registers and committed together, so the display never sees a mixed old/new time. The block sits between the top-level bus tristate wrapper and the time/format logic.

## Interface
- PHASE, 9: clock cycles per bus phase; legal range 2..255.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one read frame; sampled only in IDLE.
- ad_in  in  8  bus data returned by the RTC, from the tristate wrapper.
- ad_out  out  8  address driven onto the bus.
- ad_oe  out  1  1 = wrapper drives ad_out onto the bus.
- cs_n, ad_sel, wr_n, rd_n  out  1 each  chip select, address/data select (0 = address), write strobe, read strobe; all active-low.
- seg, min, hour, day, month, year, t_seg, t_min, t_hour  out  8 each  committed register values, raw BCD.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a new snapshot is committed.

## Operation
- Read order: idx 0..8 reads addresses 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
- Destinations, in the same order: seg, min, hour, day, month, year, t_seg, t_min, t_hour.
- States: IDLE, ADDR, ADDR_REL, DATA, DATA_REL, COMMIT.
- IDLE: all strobes high, ad_oe=0. On start=1, go to ADDR, set idx=0, clear the phase counter.
- ADDR (PHASE cycles): cs_n=0, ad_sel=0, wr_n=0, rd_n=1, ad_oe=1, ad_out=address[idx].
- ADDR_REL (PHASE cycles): strobes high, ad_oe=1, ad_out held. This preserves address hold time.
- DATA (PHASE cycles): cs_n=0, ad_sel=1, rd_n=0, wr_n=1, ad_oe=0. ad_in is captured into shadow[idx] on the edge that ends the last DATA cycle.
- DATA_REL (PHASE cycles): strobes high, ad_oe=0.
  - If idx<8: increment idx and go to ADDR.
  - If idx=8: go to COMMIT.
- COMMIT (1 cycle): copy all 9 shadow registers to the outputs, done=1, then go to IDLE.
- Phase counter: counts 0..PHASE-1, wraps to 0 on every state change. Width is 8 bits.
- start while not in IDLE: ignored, not queued.
- ad_oe and strobes never conflict. ad_oe=0 whenever rd_n=0, and wr_n and rd_n are never both 0.

## Timing
- Reset values: cs_n=ad_sel=wr_n=rd_n=1, ad_oe=0, ad_out=0x00, all 9 data outputs 0x00, busy=0, done=0, state IDLE, idx=0, shadows 0x00.
- Reset mid-frame: at the next edge all outputs return to reset values and the partial frame is discarded. Committed outputs are cleared and are not preserved.
- start=1 in IDLE sampled at edge k: busy=1 and ADDR is active starting cycle k+1.
- Register n: ADDR occupies cycles k+1+4n·PHASE .. k+(4n+1)·PHASE.
- Frame: 36·PHASE bus cycles, then COMMIT at cycle k+1+36·PHASE, with done=1 and busy=1 in that cycle.
- Outputs change at the edge ending COMMIT. busy=0 from cycle k+2+36·PHASE.
- start held high: a new frame begins one cycle after COMMIT (IDLE lasts one cycle). Frame period is 36·PHASE+2.
- Outputs are stable between commits. done is never asserted except in COMMIT.

## Test plan
- Reset/idle: reset 1 for 3 cycles, start=0 → strobes 1, ad_oe=0, busy=0, all outputs 0x00 for 100 cycles.
- Single frame (PHASE=9): RTC model returns 0x10+idx on rd_n=0, pulse start → busy for 325 cycles, done pulse at cycle k+325, seg=0x10 … t_hour=0x18. Addresses observed in ADDR phases are 0x21..0x26, 0x41..0x43, each ADDR/DATA window exactly 9 cycles.
- Coherency: change model data mid-frame (after idx 3) → outputs keep previous values until done, then update all 9 in one edge.
- Ignored start: pulse start at cycles 50 and 200 of a frame → exactly one done, no restart, period unchanged.
- Reset mid-frame: assert reset during DATA of idx 4 → next edge has strobes high, ad_oe=0, outputs 0x00. A fresh start then completes normally.
- Bus-safety assertion: on every cycle of a PHASE=2 back-to-back run, never (ad_oe=1 and rd_n=0) and never (wr_n=0 and rd_n=0).
